// File: rtl/adder_mc.sv
// rtl/adder_mc.sv - multi-cycle chunked adder/subtractor with valid/ready handshakes
module adder_mc #(
  parameter int n = 32,
  parameter int k = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int NC = n / k;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [IW-1:0] LAST = IW'(NC - 1);

  if (n % k != 0) begin : g_bad_chunk
    $error("adder_mc: n must be a multiple of k");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic          carry_q, carry_d;
  logic [n-1:0]  a_q, a_d;
  logic [n-1:0]  b_q, b_d;
  logic [n-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic          accept;
  logic [k-1:0]  chunk_a, chunk_b;
  logic [k:0]    chunk_s;

  assign in_ready  = en & ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Select the current chunk of each operand and add it with the rippled carry
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int j = 0; j < NC; j++) begin
      if (i_q == IW'(j)) begin
        chunk_a = a_q[j*k +: k];
        chunk_b = b_q[j*k +: k];
      end
    end
    chunk_s = {1'b0, chunk_a} + {1'b0, chunk_b} + {{k{1'b0}}, carry_q};
  end

  // Next-state, operand capture and per-chunk result update; everything holds while en is low
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (en) begin
      case (state_q)
        RUN: begin
          for (int j = 0; j < NC; j++) begin
            if (i_q == IW'(j)) sum_d[j*k +: k] = chunk_s[k-1:0];
          end
          carry_d = chunk_s[k];
          if (i_q == LAST) begin
            cout_d  = chunk_s[k];
            ovf_d   = (a_q[n-1] == b_q[n-1]) & (sum_d[n-1] != a_q[n-1]);
            state_d = DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: ;
      endcase
      // Subtraction is a + ~b + 1, so the borrow-in is folded into the inverted carry
      if (accept) begin
        a_d     = a;
        b_d     = sub ? ~b : b;
        carry_d = sub ? ~cin : cin;
        i_d     = '0;
        state_d = RUN;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_adder_mc.sv
// tb/tb_adder_mc.sv - scoreboard bench for adder_mc (32/8 and 8/8 instances)
module tb_adder_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, out_ready;

  logic        in_valid0, in_ready0, cin0, sub0, out_valid0, cout0, ovf0, busy0;
  logic [31:0] a0, b0, sum0;
  logic        in_valid1, in_ready1, cin1, sub1, out_valid1, cout1, ovf1, busy1;
  logic [7:0]  a1, b1, sum1;

  adder_mc #(.n(32), .k(8)) dut0 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .cin(cin0), .sub(sub0), .out_valid(out_valid0),
    .out_ready(out_ready), .sum(sum0), .cout(cout0), .ovf(ovf0), .busy(busy0)
  );

  adder_mc #(.n(8), .k(8)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
    .out_ready(out_ready), .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  logic [33:0] q0[$];
  logic [33:0] q1[$];
  time         t1[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Push expectation, present operands, wait for the accepting edge
  task automatic issue(input int d, input logic [31:0] av, input logic [31:0] bv,
                       input logic cv, input logic sv, input logic [31:0] es,
                       input logic ec, input logic eo, input bit push,
                       output logic in_done);
    bit ok = 0;
    in_done = 1'b0;
    if (push) begin
      if (d == 0) q0.push_back({es, ec, eo});
      else        q1.push_back({es, ec, eo});
    end
    if (d == 0) begin
      a0 = av; b0 = bv; cin0 = cv; sub0 = sv; in_valid0 = 1'b1;
    end else begin
      a1 = av[7:0]; b1 = bv[7:0]; cin1 = cv; sub1 = sv; in_valid1 = 1'b1;
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if ((d == 0) ? in_ready0 : in_ready1) begin
        in_done = (d == 0) ? out_valid0 : out_valid1;
        ok = 1;
        break;
      end
      @(posedge clk);
    end
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout actual=no_accept expected=accept");
    end
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  // Monitor for the 32-bit instance
  always @(negedge clk) begin
    if (!rst && en && out_ready && out_valid0) begin
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_unexpected actual=sum_0x%0h expected=no_output", sum0);
      end else begin
        logic [33:0] e;
        e = q0.pop_front();
        chk("dut0_sum", {32'd0, sum0}, {32'd0, e[33:2]});
        chk("dut0_cout", {63'd0, cout0}, {63'd0, e[1]});
        chk("dut0_ovf", {63'd0, ovf0}, {63'd0, e[0]});
      end
    end
  end

  // Monitor for the single-cycle 8-bit instance
  always @(negedge clk) begin
    if (!rst && en && out_ready && out_valid1) begin
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected actual=sum_0x%0h expected=no_output", sum1);
      end else begin
        logic [33:0] e;
        e = q1.pop_front();
        t1.push_back($time);
        chk("dut1_sum", {56'd0, sum1}, {32'd0, e[33:2]});
        chk("dut1_cout", {63'd0, cout1}, {63'd0, e[1]});
        chk("dut1_ovf", {63'd0, ovf1}, {63'd0, e[0]});
      end
    end
  end

  initial begin
    logic f1, f2, fx;
    int   lat;
    rst = 1'b1; en = 1'b1; out_ready = 1'b1;
    in_valid0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_sum", {32'd0, sum0}, 64'd0);
    chk("rst_cout_ovf", {62'd0, cout0, ovf0}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready0}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready0}, 64'd1);
    @(posedge clk); #1;

    // Reset mid-operation: abort in the second RUN cycle, no result must appear
    issue(0, 32'd1, 32'd2, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 0, fx);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_a", {63'd0, in_ready0}, 64'd0);
    chk("midrst_out_valid_a", {63'd0, out_valid0}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_sum", {32'd0, sum0}, 64'd0);
    chk("midrst_busy", {63'd0, busy0}, 64'd0);
    chk("midrst_out_valid_b", {63'd0, out_valid0}, 64'd0);
    chk("midrst_in_ready_b", {63'd0, in_ready0}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_release_in_ready", {63'd0, in_ready0}, 64'd1);
    @(posedge clk); #1;

    // Carry ripple across all chunks, with latency measurement
    issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1, fx);
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid0) break;
      @(posedge clk);
      lat++;
    end
    chk("ripple_latency", 64'(lat), 64'd4);
    @(posedge clk); #1;

    issue(0, 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, fx);
    issue(0, 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1, fx);
    issue(0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1, fx);
    issue(0, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1, fx);
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, fx);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid0) break;
    end
    @(posedge clk); #1;

    // Stall part A: en low for 3 cycles during RUN adds 3 cycles of latency
    issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1, fx);
    @(posedge clk);
    lat = 1;
    #1 en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_busy", {62'd0, busy0, out_valid0}, 64'd2);
      @(posedge clk);
      lat++;
    end
    #1 en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid0) break;
      @(posedge clk);
      lat++;
    end
    chk("stall_latency", 64'(lat), 64'd7);
    @(posedge clk); #1;

    // Stall part B: consumer back-pressure holds the result stable
    out_ready = 1'b0;
    issue(0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1, fx);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid0) break;
      @(posedge clk);
    end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("hold_sum", {32'd0, sum0}, 64'h2345_678A);
      chk("hold_in_ready", {62'd0, in_ready0, out_valid0}, 64'd1);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(posedge clk); #1;

    // Back-to-back on the single-cycle instance
    issue(1, 32'h80, 32'h80, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1, f1);
    issue(1, 32'h01, 32'h01, 1'b0, 1'b0, 32'h02, 1'b0, 1'b0, 1, f2);
    chk("b2b_op1_from_idle", {63'd0, f1}, 64'd0);
    chk("b2b_op2_in_done", {63'd0, f2}, 64'd1);

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("dut0_queue_drained", 64'(q0.size()), 64'd0);
    chk("dut1_queue_drained", 64'(q1.size()), 64'd0);
    chk("b2b_handshakes", 64'(t1.size()), 64'd2);
    if (t1.size() == 2) chk("b2b_spacing", 64'(t1[1] - t1[0]), 64'd20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
